// File: rtl/i2cmb_pkg.sv
// Purpose: shared types and constants for the I2CMB command front end.
// Ports: none (package).
package i2cmb_pkg;

  // Byte-FSM command codes
  typedef enum logic [2:0] {
    CMD_WAIT     = 3'b000,
    CMD_WRITE    = 3'b001,
    CMD_READ_ACK = 3'b010,
    CMD_READ_NAK = 3'b011,
    CMD_START    = 3'b100,
    CMD_STOP     = 3'b101,
    CMD_SET_BUS  = 3'b110
  } cmd_t;

  // Wishbone register map
  typedef enum logic [1:0] {
    ADR_CSR  = 2'd0,
    ADR_DPR  = 2'd1,
    ADR_CMDR = 2'd2,
    ADR_FSMR = 2'd3
  } reg_addr_t;

  // Completion flag bit positions within {DON,NAK,AL,ERR}
  localparam int unsigned RSP_DON = 3;
  localparam int unsigned RSP_NAK = 2;
  localparam int unsigned RSP_AL  = 1;
  localparam int unsigned RSP_ERR = 0;

  localparam int unsigned CMD_W = 11;
  localparam int unsigned RSP_W = 15;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } issue_state_t;

  // Command FIFO entry: code + operand
  typedef struct packed {
    logic [2:0] code;
    logic [7:0] data;
  } cmd_entry_t;

  // Response FIFO entry: flags + originating code + read byte
  typedef struct packed {
    logic [3:0] flags;
    logic [2:0] code;
    logic [7:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/i2cmb_sync_fifo.sv
// Purpose: synchronous FIFO with flush and occupancy count.
// Ports: clk_i/rst_i clock and sync reset; push/din write side; pop/dout
//        read side (dout shows head); full/empty/count status; flush empties.
module i2cmb_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full FIFO is legal only when the head leaves the same cycle
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  assign count = r_wr_ptr - r_rd_ptr;
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (count == CW'(DEPTH));
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush behaves like reset
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + CW'(1);
    end
  end

  // Storage array (contents are don't-care while empty)
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush && w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/i2cmb_cmd_queue.sv
// Purpose: Wishbone command front end that queues CMDR writes, issues them one
//          at a time to the byte-level I2C FSM and buffers completions.
// Ports: clk_i/rst_i clock and sync reset; cyc_i/stb_i/we_i/adr_i/dat_i/
//        dat_o/ack_o Wishbone slave; irq interrupt; cmd_valid/cmd_ready/
//        cmd_code/cmd_data command to byte FSM; rsp_valid/rsp_code/rsp_data
//        completion from byte FSM.
module i2cmb_cmd_queue
  import i2cmb_pkg::*;
#(
  parameter int unsigned NUM_BUSES = 16,
  parameter int unsigned CMD_DEPTH = 8,
  parameter int unsigned RSP_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [1:0] adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       irq,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_code,
  output logic [7:0] cmd_data,
  input  logic       rsp_valid,
  input  logic [3:0] rsp_code,
  input  logic [7:0] rsp_data
);

  localparam int unsigned CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int unsigned RSP_CW = $clog2(RSP_DEPTH) + 1;

  logic         r_ack, r_en, r_ie, r_ovf, r_irq, r_drop;
  logic [7:0]   r_dpr;
  issue_state_t r_state;
  logic [2:0]   r_cur_code;
  logic [3:0]   r_cur_bus, r_bus_id;

  reg_addr_t         w_adr;
  logic              w_wr, w_rd, w_flush, w_in_issue, w_in_wait, w_bad_bus;
  logic              w_cmd_push, w_cmd_pop, w_cmd_full, w_cmd_empty;
  logic              w_rsp_push, w_rsp_pop, w_rsp_full, w_rsp_empty;
  logic [CMD_CW-1:0] w_cmd_count;
  logic [RSP_CW-1:0] w_rsp_count;
  logic [CMD_W-1:0]  w_cmd_dout;
  logic [RSP_W-1:0]  w_rsp_dout;
  cmd_entry_t        w_cmd_head;
  rsp_entry_t        w_rsp_head, w_rsp_din;
  logic [31:0]       w_cmd_cnt32;
  logic [3:0]        w_cnt_sat;
  logic              w_unused;

  // Bus access takes effect on the ack cycle
  assign w_adr = reg_addr_t'(adr_i);
  assign w_wr  = r_ack & cyc_i & stb_i & we_i;
  assign w_rd  = r_ack & cyc_i & stb_i & ~we_i;

  // FIFOs are held flushed for as long as the block is disabled
  assign w_flush    = ~r_en;
  assign w_in_issue = r_en & (r_state == ST_ISSUE);
  assign w_in_wait  = r_en & (r_state == ST_WAIT_RSP);

  assign w_cmd_head = w_cmd_dout;
  assign w_rsp_head = w_rsp_dout;
  assign w_bad_bus  = (w_cmd_head.code == CMD_SET_BUS) &&
                      (w_cmd_head.data >= 8'(NUM_BUSES));

  assign cmd_valid = w_in_issue & ~w_bad_bus;
  assign cmd_code  = w_cmd_head.code;
  assign cmd_data  = w_cmd_head.data;
  assign ack_o     = r_ack;
  assign irq       = r_irq;

  assign w_cmd_push = w_wr & (w_adr == ADR_CMDR) & r_en & ~w_cmd_full;
  assign w_cmd_pop  = w_in_issue & (w_bad_bus | cmd_ready);
  assign w_rsp_push = (w_in_issue & w_bad_bus) | (w_in_wait & rsp_valid);
  assign w_rsp_pop  = w_rd & (w_adr == ADR_CMDR) & ~w_rsp_empty;

  assign w_cmd_cnt32 = 32'(w_cmd_count);
  assign w_cnt_sat   = (w_cmd_cnt32 > 32'd15) ? 4'hF : w_cmd_cnt32[3:0];
  assign w_unused    = &{1'b0, w_rsp_count, w_cmd_cnt32[31:4]};

  // Response entry: real completion in WAIT_RSP, local ERR for a bad bus id
  always_comb begin
    w_rsp_din = '0;
    if (w_in_wait) begin
      w_rsp_din.flags = rsp_code;
      w_rsp_din.code  = r_cur_code;
      w_rsp_din.data  = rsp_data;
    end else begin
      w_rsp_din.flags[RSP_ERR] = 1'b1;
      w_rsp_din.code           = w_cmd_head.code;
    end
  end

  // Read mux; status bits read as their reset value while disabled
  always_comb begin
    dat_o = '0;
    if (r_ack && !we_i) begin
      case (w_adr)
        ADR_CSR:  dat_o = {r_en, r_ie, w_cmd_full & r_en, w_rsp_empty & r_en,
                           r_ovf, 3'b000};
        ADR_DPR:  if (!w_rsp_empty) dat_o = w_rsp_head.data;
        ADR_CMDR: if (!w_rsp_empty) dat_o = {w_rsp_head.flags, 1'b0, w_rsp_head.code};
        ADR_FSMR: dat_o = {r_bus_id, w_cnt_sat};
        default:  dat_o = '0;
      endcase
    end
  end

  // Wishbone handshake and control/status registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack <= 1'b0;
      r_en  <= 1'b0;
      r_ie  <= 1'b0;
      r_ovf <= 1'b0;
      r_irq <= 1'b0;
      r_dpr <= '0;
    end else begin
      r_ack <= cyc_i & stb_i & ~r_ack;
      r_irq <= r_ie & r_en & ~w_rsp_empty;
      if (w_wr) begin
        case (w_adr)
          ADR_CSR: begin
            r_en <= dat_i[7];
            r_ie <= dat_i[6];
            if (dat_i[3]) r_ovf <= 1'b0;
          end
          ADR_DPR:  r_dpr <= dat_i;
          ADR_CMDR: if (!r_en || w_cmd_full) r_ovf <= 1'b1;
          default:  ;
        endcase
      end
    end
  end

  // Issue FSM: one command outstanding at a time
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_cur_code <= '0;
      r_cur_bus  <= '0;
      r_bus_id   <= '0;
      r_drop     <= 1'b0;
    end else begin
      if (rsp_valid) r_drop <= 1'b0;
      if (!r_en) begin
        r_state <= ST_IDLE;
        // Byte FSM still owes a response; swallow it when it comes
        if (r_state == ST_WAIT_RSP && !rsp_valid) r_drop <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE:
            if (!w_cmd_empty && !w_rsp_full && !r_drop) r_state <= ST_ISSUE;
          ST_ISSUE:
            if (w_bad_bus) begin
              r_state <= ST_IDLE;
            end else if (cmd_ready) begin
              r_cur_code <= w_cmd_head.code;
              r_cur_bus  <= w_cmd_head.data[3:0];
              r_state    <= ST_WAIT_RSP;
            end
          ST_WAIT_RSP:
            if (rsp_valid) begin
              if (r_cur_code == CMD_SET_BUS && rsp_code[RSP_DON]) r_bus_id <= r_cur_bus;
              r_state <= ST_IDLE;
            end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  i2cmb_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH), .CW(CMD_CW)) u_cmd_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .flush (w_flush),
    .push  (w_cmd_push),
    .pop   (w_cmd_pop),
    .din   ({dat_i[2:0], r_dpr}),
    .dout  (w_cmd_dout),
    .full  (w_cmd_full),
    .empty (w_cmd_empty),
    .count (w_cmd_count)
  );

  i2cmb_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH), .CW(RSP_CW)) u_rsp_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .flush (w_flush),
    .push  (w_rsp_push),
    .pop   (w_rsp_pop),
    .din   (w_rsp_din),
    .dout  (w_rsp_dout),
    .full  (w_rsp_full),
    .empty (w_rsp_empty),
    .count (w_rsp_count)
  );

endmodule

// File: tb/tb_i2cmb_cmd_queue.sv
// Purpose: scoreboard bench for i2cmb_cmd_queue. Directed stimulus pushes the
//          expected Wishbone read data and byte-FSM commands into queues; a
//          monitor pops and compares whenever the DUT presents them.
module tb_i2cmb_cmd_queue;

  localparam logic [1:0] A_CSR = 2'd0, A_DPR = 2'd1, A_CMDR = 2'd2, A_FSMR = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0] adr = '0;
  logic [7:0] wdat = '0;
  logic [7:0] dat_o;
  logic       ack_o, irq, cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [2:0] cmd_code;
  logic [7:0] cmd_data;
  logic       rsp_valid = 1'b0;
  logic [3:0] rsp_code = '0;
  logic [7:0] rsp_data = '0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  q_rd[$];
  logic [10:0] q_cmd[$];

  i2cmb_cmd_queue #(.NUM_BUSES(16), .CMD_DEPTH(8), .RSP_DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .adr_i(adr), .dat_i(wdat), .dat_o(dat_o), .ack_o(ack_o), .irq(irq),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_code(rsp_code),
    .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled mid-cycle, inputs change just after posedge
  always @(negedge clk) begin
    if (!rst && ack_o && !we) begin
      if (q_rd.size() == 0) chk("rd_unexpected", 32'(dat_o), 32'hFFFF_FFFF);
      else chk("rd_data", 32'(dat_o), 32'(q_rd.pop_front()));
    end
    if (!rst && cmd_valid && cmd_ready) begin
      if (q_cmd.size() == 0) chk("cmd_unexpected", 32'({cmd_code, cmd_data}), 32'hFFFF_FFFF);
      else chk("cmd_issue", 32'({cmd_code, cmd_data}), 32'(q_cmd.pop_front()));
    end
  end

  task automatic xfer(input logic w, input logic [1:0] a, input logic [7:0] d,
                      input logic pulse, input logic [3:0] rc, input logic [7:0] rdat);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    @(posedge clk); #1;
    if (pulse) begin
      rsp_valid = 1'b1; rsp_code = rc; rsp_data = rdat;
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rsp_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    xfer(1'b1, a, d, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic rdchk(input logic [1:0] a, input logic [7:0] exp);
    q_rd.push_back(exp);
    xfer(1'b0, a, 8'h00, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic ready_pulse();
    @(posedge clk); #1; cmd_ready = 1'b1;
    @(posedge clk); #1; cmd_ready = 1'b0;
  endtask

  task automatic rsp_pulse(input logic [3:0] rc, input logic [7:0] rdat);
    @(posedge clk); #1; rsp_valid = 1'b1; rsp_code = rc; rsp_data = rdat;
    @(posedge clk); #1; rsp_valid = 1'b0;
  endtask

  // Write CMDR, expect it on the command port, accept it and complete it
  task automatic run_cmd(input logic [2:0] code, input logic [7:0] exp_data,
                         input logic [3:0] rc, input logic [7:0] rdat);
    wr(A_CMDR, {5'b0, code});
    q_cmd.push_back({code, exp_data});
    repeat (2) @(posedge clk);
    ready_pulse();
    rsp_pulse(rc, rdat);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    do_reset();

    // 1: reset state
    @(negedge clk);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_ack", 32'(ack_o), 0);
    rdchk(A_CSR, 8'h00);
    rdchk(A_DPR, 8'h00);
    rdchk(A_CMDR, 8'h00);
    rdchk(A_FSMR, 8'h00);

    // 2: single WRITE with back-pressure, completion and irq
    wr(A_CSR, 8'hC0);
    rdchk(A_CSR, 8'hD0);
    wr(A_DPR, 8'h5A);
    wr(A_CMDR, 8'h01);
    repeat (3) @(negedge clk);
    chk("t2_cmd_valid", 32'(cmd_valid), 1);
    chk("t2_cmd_code", 32'(cmd_code), 1);
    chk("t2_cmd_data", 32'(cmd_data), 32'h5A);
    q_cmd.push_back({3'b001, 8'h5A});
    ready_pulse();
    rsp_pulse(4'h8, 8'h00);
    repeat (2) @(negedge clk);
    chk("t2_irq_set", 32'(irq), 1);
    rdchk(A_CMDR, 8'h81);
    repeat (2) @(negedge clk);
    chk("t2_irq_clr", 32'(irq), 0);

    // 3: fill the command FIFO, overflow, clear OVF, flush
    for (int i = 0; i < 8; i++) wr(A_CMDR, 8'h01);
    rdchk(A_FSMR, 8'h08);
    rdchk(A_CSR, 8'hF0);
    wr(A_CMDR, 8'h01);
    rdchk(A_CSR, 8'hF8);
    wr(A_CMDR, 8'h01);
    rdchk(A_FSMR, 8'h08);
    wr(A_CSR, 8'hC8);
    rdchk(A_CSR, 8'hF0);
    wr(A_CSR, 8'h00);
    wr(A_CSR, 8'hC0);
    rdchk(A_FSMR, 8'h00);
    rdchk(A_CSR, 8'hD0);

    // 4: SET_BUS out of range, then in range
    wr(A_DPR, 8'h10);
    wr(A_CMDR, 8'h06);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | cmd_valid;
    end
    chk("t4_no_valid", 32'(seen), 0);
    rdchk(A_CMDR, 8'h16);
    wr(A_DPR, 8'h03);
    run_cmd(3'b110, 8'h03, 4'h8, 8'h00);
    repeat (2) @(posedge clk);
    rdchk(A_FSMR, 8'h30);
    rdchk(A_CMDR, 8'h86);

    // 5: response push coincides with pop of an older entry
    run_cmd(3'b001, 8'h03, 4'h8, 8'h00);
    wr(A_CMDR, 8'h02);
    q_cmd.push_back({3'b010, 8'h03});
    repeat (2) @(posedge clk);
    ready_pulse();
    q_rd.push_back(8'h81);
    xfer(1'b0, A_CMDR, 8'h00, 1'b1, 4'h8, 8'hC3);
    rdchk(A_DPR, 8'hC3);
    rdchk(A_CSR, 8'hC0);
    rdchk(A_CMDR, 8'h82);
    rdchk(A_CMDR, 8'h00);

    // 6: disable while a response is pending
    wr(A_CMDR, 8'h01);
    q_cmd.push_back({3'b001, 8'h03});
    repeat (2) @(posedge clk);
    ready_pulse();
    wr(A_CSR, 8'h40);
    rsp_pulse(4'h8, 8'hEE);
    rdchk(A_CSR, 8'h40);
    rdchk(A_DPR, 8'h00);
    rdchk(A_CMDR, 8'h00);
    @(negedge clk);
    chk("t6_irq", 32'(irq), 0);
    wr(A_CSR, 8'hC0);
    rdchk(A_CSR, 8'hD0);
    wr(A_DPR, 8'h77);
    run_cmd(3'b001, 8'h77, 4'h8, 8'h00);
    rdchk(A_CMDR, 8'h81);
    rdchk(A_CSR, 8'hD0);

    // 7: reset mid-operation
    wr(A_CMDR, 8'h01);
    wr(A_CMDR, 8'h01);
    do_reset();
    @(negedge clk);
    chk("t7_cmd_valid", 32'(cmd_valid), 0);
    rdchk(A_FSMR, 8'h00);
    rdchk(A_CSR, 8'h00);

    repeat (2) @(negedge clk);
    chk("rd_queue_drained", 32'(q_rd.size()), 0);
    chk("cmd_queue_drained", 32'(q_cmd.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
